vend_credit_ctrl: RTL and testbench
===================================

// Module: vend_credit_ctrl
// PURPOSE
//  Parametrised coin-operated vending controller, successor to the fixed-price newspaper FSM.
//  Accumulates nickel/dime/quarter credit against a parameterised price and releases one item.
//  Dispenses change through a request/acknowledge handshake, and refunds all credit on cancel.
//  Sits between the coin-acceptor front end and the release/hopper actuator drivers.
// PARAMETERS
//  PRICE      7  item price in nickels (7 = 35c); legal range 1..(2**CREDIT_W - 9)
//  CREDIT_W   4  credit register width in nickels; must hold PRICE-1+8 (all three coins in one cycle)
//  DIME_CHG   1  1 = change paid in dimes first, then nickels; 0 = nickels only
// PORTS
//  clk        in   1         system clock, all state updates on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  N          in   1         nickel inserted, one-cycle pulse (+1)
//  D          in   1         dime inserted, one-cycle pulse (+2)
//  Q          in   1         quarter inserted, one-cycle pulse (+5)
//  cancel     in   1         refund request, one-cycle pulse
//  rel_ack    in   1         release mechanism done
//  hop_ack    in   1         hopper has ejected the requested coin
//  R          out  1         release request, level, held until rel_ack
//  N1         out  1         eject-nickel request, level, held until hop_ack
//  D1         out  1         eject-dime request, level, held until hop_ack
//  accept_en  out  1         1 only in COLLECT; acceptor must reject coins when 0
//  credit     out  CREDIT_W  current credit/change balance in nickels
// BEHAVIOUR
//  Reset (async, rst_n=0): state=COLLECT, credit=0, R=N1=D1=0, accept_en=1. Reset mid-vend or
//   mid-change abandons the operation; credit is lost.
//  Coin value per cycle = N + 2*D + 5*Q; simultaneous coins are summed, none dropped.
//  COLLECT: sum = credit + coin value.
//   - sum >= PRICE: credit <= sum-PRICE, R<=1, state<=VEND. This has registered latency 1:
//     R is high the cycle after the final coin pulse.
//   - else if cancel: credit <= sum (coins in the same cycle are counted, then refunded),
//     state <= CHANGE if sum>0, else stay.
//   - else credit <= sum.
//   - A purchase takes priority over cancel in the same cycle; remainder is paid as change.
//  VEND: R held 1. On a rel_ack sample: R<=0; state <= CHANGE if credit>0, else COLLECT.
//  CHANGE: one coin per handshake.
//   - Request D1 if DIME_CHG and credit>=2, else N1. Only one of D1/N1 is high at a time.
//   - On a hop_ack sample: request drops, credit -= 2 (dime) or 1 (nickel).
//   - Next request is raised no earlier than the following cycle (min 1 idle cycle low).
//   - credit==0 after decrement -> COLLECT.
//  Outside COLLECT: N/D/Q/cancel are ignored (accept_en=0). rel_ack/hop_ack are ignored
//   unless the matching request is high.
//  Credit never wraps. Parameter legality is checked with an elaboration-time assertion.
//  States: COLLECT, VEND, CHANGE (2-bit encoding); unused encoding -> COLLECT with credit=0.
// TESTING
//  1 PRICE=7: Q,D pulses -> R=1 one cycle after D, credit=0; rel_ack -> COLLECT, no N1/D1.
//  2 Q,Q (10 nickels) -> R, credit=3; after rel_ack: D1 then N1, each held until hop_ack;
//    credit 3->1->0, back to COLLECT.
//  3 D,N then cancel -> CHANGE, credit=3 refunded as D1,N1; with DIME_CHG=0: N1 x3.
//  4 N,D,Q in same cycle from credit=0 -> credit 8>=7: R=1, change 1 nickel after rel_ack.
//  5 Q pulse during VEND -> ignored, credit unchanged, accept_en=0 throughout.
//  6 rst_n low while D1 high awaiting hop_ack -> D1=R=N1=0, credit=0, COLLECT immediately.

Source files
------------

// File: rtl/vend_credit_ctrl.sv
// Coin-operated vending controller: accumulates N/D/Q credit against PRICE, releases one item,
// then pays back any remainder (or a cancelled balance) one coin per hopper handshake.
module vend_credit_ctrl #(
    parameter int PRICE    = 7,
    parameter int CREDIT_W = 4,
    parameter int DIME_CHG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    input  logic                rel_ack,
    input  logic                hop_ack,
    output logic                R,
    output logic                N1,
    output logic                D1,
    output logic                accept_en,
    output logic [CREDIT_W-1:0] credit
);

    localparam int SUM_W = CREDIT_W + 1;

    if (PRICE < 1 || PRICE > (2**CREDIT_W) - 9) begin : g_bad_param
        $error("vend_credit_ctrl: PRICE must lie in 1..2**CREDIT_W-9");
    end

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_VEND    = 2'd1,
        S_CHANGE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                r_q, r_d, n1_q, n1_d, d1_q, d1_d;
    logic [SUM_W-1:0]    coin_val, sum;
    logic [CREDIT_W-1:0] dec, credit_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_COLLECT;
            credit_q <= '0;
            r_q      <= 1'b0;
            n1_q     <= 1'b0;
            d1_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            r_q      <= r_d;
            n1_q     <= n1_d;
            d1_q     <= d1_d;
        end
    end

    // Simultaneous coins are summed; the extra sum bit plus the PRICE bound keeps this from wrapping.
    assign coin_val    = SUM_W'(N) + (SUM_W'(D) << 1) + (SUM_W'(Q) * SUM_W'(5));
    assign sum         = {1'b0, credit_q} + coin_val;
    assign dec         = d1_q ? CREDIT_W'(2) : CREDIT_W'(1);
    assign credit_left = credit_q - dec;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        r_d      = r_q;
        n1_d     = n1_q;
        d1_d     = d1_q;
        case (state_q)
            S_COLLECT: begin
                n1_d = 1'b0;
                d1_d = 1'b0;
                if (sum >= SUM_W'(PRICE)) begin
                    credit_d = CREDIT_W'(sum - SUM_W'(PRICE));
                    r_d      = 1'b1;
                    state_d  = S_VEND;
                end else begin
                    r_d      = 1'b0;
                    credit_d = CREDIT_W'(sum);
                    if (cancel && sum != '0) state_d = S_CHANGE;
                end
            end
            S_VEND: begin
                if (rel_ack) begin
                    r_d     = 1'b0;
                    state_d = (credit_q != '0) ? S_CHANGE : S_COLLECT;
                end
            end
            S_CHANGE: begin
                // A request is only raised from an idle cycle, guaranteeing one low cycle between coins.
                if (n1_q || d1_q) begin
                    if (hop_ack) begin
                        n1_d     = 1'b0;
                        d1_d     = 1'b0;
                        credit_d = credit_left;
                        if (credit_left == '0) state_d = S_COLLECT;
                    end
                end else if (credit_q == '0) begin
                    state_d = S_COLLECT;
                end else if (DIME_CHG != 0 && credit_q >= CREDIT_W'(2)) begin
                    d1_d = 1'b1;
                end else begin
                    n1_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_COLLECT;
                credit_d = '0;
                r_d      = 1'b0;
                n1_d     = 1'b0;
                d1_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        accept_en = (state_q == S_COLLECT);
        R         = r_q;
        N1        = n1_q;
        D1        = d1_q;
        credit    = credit_q;
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Scoreboard bench for vend_credit_ctrl: expected release/eject requests are queued as coins are
// driven and popped as the DUT raises each handshake request.
module tb_vend_credit_ctrl;

    logic clk = 1'b0;
    logic rst_n, N, D, Q, cancel;
    logic rel_ack, hop_ack, rel_ack0, hop_ack0;
    logic R, N1, D1, acc;
    logic R0, N10, D10, acc0;
    logic [3:0] cr, cr0;

    typedef struct {
        int kind;  // 0 = release, 1 = nickel, 2 = dime
        int cred;  // credit shown while the request is up
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    vend_credit_ctrl #(.PRICE(7), .CREDIT_W(4), .DIME_CHG(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .N(N), .D(D), .Q(Q), .cancel(cancel),
        .rel_ack(rel_ack), .hop_ack(hop_ack),
        .R(R), .N1(N1), .D1(D1), .accept_en(acc), .credit(cr)
    );

    vend_credit_ctrl #(.PRICE(7), .CREDIT_W(4), .DIME_CHG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .N(N), .D(D), .Q(Q), .cancel(cancel),
        .rel_ack(rel_ack0), .hop_ack(hop_ack0),
        .R(R0), .N1(N10), .D1(D10), .accept_en(acc0), .credit(cr0)
    );

    task automatic apply_reset();
        rst_n = 1'b0; N = 0; D = 0; Q = 0; cancel = 0;
        rel_ack = 0; hop_ack = 0; rel_ack0 = 0; hop_ack0 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse(input logic n, input logic d, input logic q, input logic c);
        N = n; D = d; Q = q; cancel = c;
        @(negedge clk);
        N = 0; D = 0; Q = 0; cancel = 0;
    endtask

    // Services every request of one instance, comparing each against the queue head.
    task automatic drain(input bit sel);
        logic r, n1, d1, a;
        int   c, kind;
        bit   done;
        exp_t e;
        done = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            r = sel ? R : R0; n1 = sel ? N1 : N10; d1 = sel ? D1 : D10;
            a = sel ? acc : acc0; c = sel ? int'(cr) : int'(cr0);
            checks++;
            if (n1 && d1) begin errors++; $display("FAIL onehot_req: N1=%b D1=%b, need at most one", n1, d1); end
            if (r || n1 || d1) begin
                kind = r ? 0 : (d1 ? 2 : 1);
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL unexpected_req: kind=%0d credit=%0d, none expected", kind, c);
                end else begin
                    e = sb.pop_front();
                    if (e.kind !== kind || e.cred !== c) begin
                        errors++;
                        $display("FAIL req_match: got kind=%0d credit=%0d, expected kind=%0d credit=%0d", kind, c, e.kind, e.cred);
                    end
                end
                if (sel) begin rel_ack = r; hop_ack = !r; end
                else     begin rel_ack0 = r; hop_ack0 = !r; end
                @(negedge clk);
                rel_ack = 0; hop_ack = 0; rel_ack0 = 0; hop_ack0 = 0;
                r = sel ? R : R0; n1 = sel ? N1 : N10; d1 = sel ? D1 : D10;
                checks++;
                if (r || n1 || d1) begin errors++; $display("FAIL req_drop: R=%b N1=%b D1=%b after ack, need all 0", r, n1, d1); end
            end else if (a && sb.size() == 0) begin
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL drain_timeout: %0d expected requests left, accept_en not back", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({R, N1, D1, acc, cr} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            errors++; $display("FAIL reset: R N1 D1 acc credit = %b %b %b %b %0d, need 0 0 0 1 0", R, N1, D1, acc, cr);
        end
    endtask

    task automatic test_single_vend();
        apply_reset();
        pulse(0, 0, 1, 0);
        checks++;
        if (cr !== 4'd5 || R !== 1'b0) begin errors++; $display("FAIL vend_q: credit=%0d R=%b, need 5 0", cr, R); end
        pulse(0, 1, 0, 0);
        checks++;
        if (R !== 1'b1 || cr !== 4'd0 || acc !== 1'b0) begin
            errors++; $display("FAIL vend_d: R=%b credit=%0d acc=%b, need 1 0 0", R, cr, acc);
        end
        sb.push_back('{0, 0});
        drain(1);
    endtask

    task automatic test_change();
        apply_reset();
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        checks++;
        if (R !== 1'b1 || cr !== 4'd3) begin errors++; $display("FAIL change_vend: R=%b credit=%0d, need 1 3", R, cr); end
        sb.push_back('{0, 3}); sb.push_back('{2, 3}); sb.push_back('{1, 1});
        drain(1);
        checks++;
        if (cr !== 4'd0 || acc !== 1'b1) begin errors++; $display("FAIL change_end: credit=%0d acc=%b, need 0 1", cr, acc); end
    endtask

    task automatic test_cancel();
        apply_reset();
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 0, 1);
        checks++;
        if (cr !== 4'd3 || acc !== 1'b0 || cr0 !== 4'd3) begin
            errors++; $display("FAIL cancel: credit=%0d acc=%b credit0=%0d, need 3 0 3", cr, acc, cr0);
        end
        sb.push_back('{2, 3}); sb.push_back('{1, 1});
        drain(1);
        sb.push_back('{1, 3}); sb.push_back('{1, 2}); sb.push_back('{1, 1});
        drain(0);
        apply_reset();
        pulse(0, 0, 0, 1);
        checks++;
        if (acc !== 1'b1 || cr !== 4'd0) begin errors++; $display("FAIL cancel_empty: acc=%b credit=%0d, need 1 0", acc, cr); end
        pulse(0, 1, 0, 0);
        rel_ack = 1; hop_ack = 1;
        @(negedge clk);
        rel_ack = 0; hop_ack = 0;
        checks++;
        if ({R, N1, D1, acc, cr} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd2}) begin
            errors++; $display("FAIL stray_ack: R N1 D1 acc credit = %b %b %b %b %0d, need 0 0 0 1 2", R, N1, D1, acc, cr);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        pulse(1, 1, 1, 0);
        checks++;
        if (R !== 1'b1 || cr !== 4'd1) begin errors++; $display("FAIL ndq: R=%b credit=%0d, need 1 1", R, cr); end
        sb.push_back('{0, 1}); sb.push_back('{1, 1});
        drain(1);
        pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 1);
        checks++;
        if (R !== 1'b1 || cr !== 4'd0) begin errors++; $display("FAIL buy_over_cancel: R=%b credit=%0d, need 1 0", R, cr); end
        sb.push_back('{0, 0});
        drain(1);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 1, 0);
        checks++;
        if (R !== 1'b1 || cr !== 4'd7) begin errors++; $display("FAIL max_sum: R=%b credit=%0d, need 1 7", R, cr); end
        sb.push_back('{0, 7}); sb.push_back('{2, 7}); sb.push_back('{2, 5});
        sb.push_back('{2, 3}); sb.push_back('{1, 1});
        drain(1);
    endtask

    task automatic test_ignore_in_vend();
        apply_reset();
        pulse(0, 0, 1, 0);
        pulse(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0, 1, 1);
            checks++;
            if (cr !== 4'd0 || acc !== 1'b0 || R !== 1'b1) begin
                errors++; $display("FAIL vend_ignore[%0d]: credit=%0d acc=%b R=%b, need 0 0 1", i, cr, acc, R);
            end
        end
        sb.push_back('{0, 0});
        drain(1);
    endtask

    task automatic test_reset_mid_change();
        bit seen;
        apply_reset();
        pulse(0, 0, 1, 0);
        pulse(0, 0, 1, 0);
        rel_ack = 1;
        @(negedge clk);
        rel_ack = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (D1 === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_change_d1: D1=%b, need 1 within 10 cycles", D1); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({R, N1, D1, acc, cr} !== {1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            errors++; $display("FAIL async_reset: R N1 D1 acc credit = %b %b %b %b %0d, need 0 0 0 1 0", R, N1, D1, acc, cr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_vend();
        test_change();
        test_cancel();
        test_simultaneous();
        test_ignore_in_vend();
        test_reset_mid_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1);
    end

endmodule
